// File: rtl/manchester_rx_pkg.sv
// rtl/manchester_rx_pkg.sv - shared types and constants for the Manchester decoder
package manchester_rx_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int MIN_BIT_CYC = 8;
    localparam int VIOL_W      = 8;

    function automatic logic [VIOL_W-1:0] sat_inc(input logic [VIOL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/manchester_rx_sig_sync_edge.sv
// rtl/manchester_rx_sig_sync_edge.sv - two-flop synchronizer plus edge register
module sig_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_level,
    output logic o_edge,
    output logic o_rising
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_sig;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_level  = r_s2;
    assign o_edge   = r_s2 ^ r_prev;
    assign o_rising = r_s2 & ~r_prev;

endmodule

// File: rtl/manchester_rx.sv
// rtl/manchester_rx.sv - Manchester decoder: recovers NRZ bits, bit clock, lock and violations
module manchester_rx
    import manchester_rx_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic [CNT_W-1:0]  bit_cyc,
    output logic              rx_bit,
    output logic              rx_valid,
    output logic              rx_clk,
    output logic [SR_W-1:0]   rx_word,
    output logic              locked,
    output logic [VIOL_W-1:0] viol_cnt
);

    logic w_level;
    logic w_edge;
    logic w_rising;

    sig_sync_edge u_sync (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sig    (sig_in),
        .o_level  (w_level),
        .o_edge   (w_edge),
        .o_rising (w_rising)
    );

    logic [CNT_W-1:0]  r_t;
    logic [CNT_W-1:0]  r_q;
    logic [CNT_W-1:0]  r_lo;
    logic [CNT_W-1:0]  r_hi;
    logic [CNT_W-1:0]  r_half;
    logic [CNT_W-1:0]  r_bc;
    state_t            r_state;
    logic              r_bit;
    logic              r_valid;
    logic              r_clk;
    logic [SR_W-1:0]   r_word;
    logic              r_locked;
    logic [VIOL_W-1:0] r_viol;

    logic [CNT_W-1:0] w_bc_eff;
    logic             w_rate_chg;
    logic             w_in_win;
    logic             w_short;
    logic             w_late;

    // Below-minimum periods would collapse the windows, so they are clamped.
    assign w_bc_eff   = (bit_cyc < CNT_W'(MIN_BIT_CYC)) ? CNT_W'(MIN_BIT_CYC) : bit_cyc;
    assign w_rate_chg = (bit_cyc != r_bc);
    assign w_in_win   = (r_t >= r_lo) && (r_t <= r_hi);
    assign w_short    = (r_t < r_q);
    assign w_late     = (r_t > r_hi);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_half <= '0;
            r_bc   <= '0;
        end else begin
            r_q    <= w_bc_eff >> 2;
            r_lo   <= w_bc_eff - (w_bc_eff >> 2);
            r_hi   <= w_bc_eff + (w_bc_eff >> 2);
            r_half <= w_bc_eff >> 1;
            r_bc   <= bit_cyc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_t      <= '0;
            r_bit    <= 1'b0;
            r_valid  <= 1'b0;
            r_clk    <= 1'b0;
            r_word   <= '0;
            r_locked <= 1'b0;
            r_viol   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (r_t != '1)
                r_t <= r_t + 1'b1;
            case (r_state)
                HUNT: begin
                    if (w_edge) begin
                        r_t <= CNT_W'(1);
                        if (w_in_win) begin
                            r_state  <= TRACK;
                            r_locked <= 1'b1;
                            r_valid  <= 1'b1;
                            r_clk    <= 1'b1;
                            r_bit    <= w_rising;
                            r_word   <= {r_word[SR_W-2:0], w_level};
                        end
                    end
                end
                TRACK: begin
                    if (r_t == r_half)
                        r_clk <= 1'b0;
                    if (w_rate_chg) begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_clk    <= 1'b0;
                    end else if (w_edge && w_in_win) begin
                        r_t     <= CNT_W'(1);
                        r_valid <= 1'b1;
                        r_clk   <= 1'b1;
                        r_bit   <= w_rising;
                        r_word  <= {r_word[SR_W-2:0], w_level};
                    end else if ((w_edge && w_short) || w_late) begin
                        // A late edge is handled as the timeout plus a fresh HUNT edge.
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_clk    <= 1'b0;
                        r_viol   <= sat_inc(r_viol);
                        if (w_edge && w_late)
                            r_t <= CNT_W'(1);
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    assign rx_bit   = r_bit;
    assign rx_valid = r_valid;
    assign rx_clk   = r_clk;
    assign rx_word  = r_word;
    assign locked   = r_locked;
    assign viol_cnt = r_viol;

endmodule

// File: tb/tb_manchester_rx.sv
// tb/tb_manchester_rx.sv - randomized self-checking bench for manchester_rx
`timescale 1ns/1ps
module tb_manchester_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] bit_cyc = 16'd20;
    logic        rx_bit;
    logic        rx_valid;
    logic        rx_clk;
    logic [7:0]  rx_word;
    logic        locked;
    logic [7:0]  viol_cnt;

    manchester_rx #(.CNT_W(16), .SR_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .bit_cyc  (bit_cyc),
        .rx_bit   (rx_bit),
        .rx_valid (rx_valid),
        .rx_clk   (rx_clk),
        .rx_word  (rx_word),
        .locked   (locked),
        .viol_cnt (viol_cnt)
    );

    always #2.5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Expected observable events, stamped with the cycle they should be seen.
    typedef struct {int c; bit b; int half;} emit_t;
    typedef struct {int c; bit lk; bit v;} ev_t;
    emit_t eq[$];
    ev_t   lq[$];

    bit lvl[$];
    bit b_lvl = 1'b0;
    bit m_prev = 1'b0;
    bit m_trk = 1'b0;
    int m_ref = -1000000;
    int m_bc = 20;

    task automatic model_flush(input int now);
        if (m_trk && (now - m_ref) > m_bc + m_bc / 4) begin
            lq.push_back('{c: m_ref + m_bc + m_bc / 4 + 1 + 3, lk: 1'b0, v: 1'b1});
            m_trk = 1'b0;
        end
    endtask

    task automatic model_edge(input int c, input bit pol);
        int q, lo, hi, d;
        q  = m_bc / 4;
        lo = m_bc - q;
        hi = m_bc + q;
        model_flush(c);
        d = c - m_ref;
        if (!m_trk) begin
            if (d >= lo && d <= hi) begin
                m_trk = 1'b1;
                lq.push_back('{c: c + 3, lk: 1'b1, v: 1'b0});
                eq.push_back('{c: c + 3, b: pol, half: m_bc / 2});
            end
            m_ref = c;
        end else if (d < q) begin
            m_trk = 1'b0;
            lq.push_back('{c: c + 3, lk: 1'b0, v: 1'b1});
        end else if (d >= lo) begin
            eq.push_back('{c: c + 3, b: pol, half: m_bc / 2});
            m_ref = c;
        end
    endtask

    task automatic run(input bit l, input int n);
        repeat (n) lvl.push_back(l);
        b_lvl = l;
    endtask

    function automatic int jv(input int j);
        return int'($urandom_range(unsigned'(2 * j))) - j;
    endfunction

    task automatic manch(input bit b, input int half, input int jit);
        run(~b, half + jv(jit));
        run(b, half + jv(jit));
    endtask

    task automatic rand_bits(input int n, input int half, input int jit);
        for (int i = 0; i < n; i++) manch(1'($urandom_range(1)), half, jit);
    endtask

    task automatic play();
        int base;
        base = cyc + 1;
        for (int i = 0; i < lvl.size(); i++) begin
            if (lvl[i] != m_prev) model_edge(base + i, lvl[i]);
            m_prev = lvl[i];
        end
        model_flush(base + lvl.size() - 1);
        for (int i = 0; i < lvl.size(); i++) begin
            @(posedge clk);
            #1 sig_in = lvl[i];
        end
        lvl.delete();
    endtask

    task automatic set_rate(input int v);
        @(posedge clk);
        #1 bit_cyc = 16'(v);
        model_flush(cyc - 2);
        if (m_trk) begin
            m_trk = 1'b0;
            lq.push_back('{c: cyc + 1, lk: 1'b0, v: 1'b0});
        end
        m_bc = v;
    endtask

    bit       mon_en = 1'b0;
    bit       exp_locked = 1'b0;
    bit       exp_valid;
    bit       exp_bit = 1'b0;
    bit [7:0] exp_word = '0;
    int       exp_viol = 0;
    int       last_e = -1000000;
    int       half_e = 1;

    always @(negedge clk) begin
        if (mon_en) begin
            while (lq.size() > 0 && lq[0].c <= cyc) begin
                exp_locked = lq[0].lk;
                if (lq[0].v && exp_viol < 255) exp_viol++;
                void'(lq.pop_front());
            end
            exp_valid = (eq.size() > 0) && (eq[0].c == cyc);
            check("rx_valid", rx_valid, exp_valid);
            if (exp_valid) begin
                exp_bit  = eq[0].b;
                exp_word = {exp_word[6:0], exp_bit};
                last_e   = cyc;
                half_e   = eq[0].half;
                void'(eq.pop_front());
            end
            check("rx_bit", rx_bit, exp_bit);
            check("rx_word", rx_word, exp_word);
            check("locked", locked, exp_locked);
            check("viol_cnt", viol_cnt, exp_viol);
            check("rx_clk", rx_clk, exp_locked && (cyc - last_e) < half_e);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_bit"}, rx_bit, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_clk"}, rx_clk, 0);
        check({tag, "_rx_word"}, rx_word, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_viol_cnt"}, viol_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        mon_en = 1'b1;

        // Preamble bit 0 then 1,0,1,1,0,0 at bit_cyc=20.
        run(0, 40);
        manch(0, 10, 0);
        manch(1, 10, 0); manch(0, 10, 0); manch(1, 10, 0);
        manch(1, 10, 0); manch(0, 10, 0); manch(0, 10, 0);
        play();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t1_word_low6", rx_word[5:0], 6'b101100);
        check("t1_locked", locked, 1);
        check("t1_viol", viol_cnt, 0);

        // Static line until the window closes.
        run(0, 40);
        play();
        @(negedge clk);
        check("t3_locked", locked, 0);
        check("t3_viol", viol_cnt, 1);
        check("t3_rx_clk", rx_clk, 0);

        // All ones never shows a long run; a 1->0 pair does.
        run(0, 40);
        for (int i = 0; i < 10; i++) manch(1, 10, 0);
        play();
        @(negedge clk);
        check("t2_no_lock", locked, 0);
        manch(0, 10, 0); manch(1, 10, 0); manch(0, 10, 0);
        run(b_lvl, 40);
        play();

        // Glitch shortly after a mid-bit edge, then relock.
        run(0, 40);
        manch(0, 10, 0); manch(1, 10, 0);
        lvl = lvl[0:lvl.size() - 11];
        run(1, 3); run(0, 3); run(1, 14);
        rand_bits(8, 10, 0);
        run(b_lvl, 40);
        play();

        // Jittered mid edges at 15 and 25, boundary-class edge at 14, then timeout.
        run(0, 40); run(1, 20); run(0, 15); run(1, 25); run(0, 14); run(1, 40);
        play();

        run(b_lvl, 40);
        rand_bits(150, 10, 3);
        run(b_lvl, 40);
        play();

        run(0, 40);
        play();
        for (int i = 0; i < 260; i++) begin
            run(1, 15 + int'($urandom_range(10)));
            run(0, 26 + int'($urandom_range(14)));
            play();
        end
        @(negedge clk);
        check("viol_saturated", viol_cnt, 255);

        // Rate change while locked, then relock at the slow rate.
        run(0, 40);
        manch(0, 10, 0);
        rand_bits(5, 10, 0);
        run(b_lvl, 3);
        play();
        set_rate(200);
        run(b_lvl, 300);
        manch(0, 100, 0);
        rand_bits(10, 100, 10);
        play();
        @(negedge clk);
        check("pre_rst_locked", locked, 1);
        check("pre_rst_viol", viol_cnt, 255);

        mon_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        sig_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_trk = 1'b0; m_ref = -1000000; m_prev = 1'b0; b_lvl = 1'b0;
        eq.delete(); lq.delete();
        exp_locked = 1'b0; exp_bit = 1'b0; exp_word = '0; exp_viol = 0;
        last_e = -1000000;
        mon_en = 1'b1;
        run(0, 300);
        manch(0, 100, 0);
        rand_bits(4, 100, 10);
        run(b_lvl, 300);
        play();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("emit_queue_drained", eq.size(), 0);
        check("event_queue_drained", lq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/manchester_rx.md
Name: manchester_rx

Overview:
- Downstream of the Manchester clock-recovery stage.
- Consumes the externally looped-back Manchester stream (same net as sig_v2a) and recovers NRZ data bits, a bit-valid strobe, a regenerated bit clock, a lock flag and a code-violation count.
- Outputs feed the display path and the error checker against the M_1 source.
- Runs on the 200 MHz system clock. Bit period is supplied at runtime by the top from the button rate setting.

Parameters:
- CNT_W, 16, width of the bit-period and interval counters.
- SR_W, 8, width of the received-bit shift register.

Ports:
- clk  in  1  system clock (200 MHz PLL output)
- rst_n  in  1  reset, synchronous, active-low
- sig_in  in  1  asynchronous Manchester input
- bit_cyc  in  CNT_W  nominal bit period in clk cycles; legal range 8..2^CNT_W-1-bit_cyc/4
- rx_bit  out  1  last decoded bit
- rx_valid  out  1  one-cycle strobe per decoded bit
- rx_clk  out  1  regenerated bit clock
- rx_word  out  SR_W  last SR_W bits; newest bit in LSB
- locked  out  1  decoder in TRACK
- viol_cnt  out  8  saturating code-violation count

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state=HUNT, counters 0, synchronizer flops 0.
- Input path: 2-flop synchronizer, then an edge register. An edge is a change between sync stage 2 and the edge register. Edge polarity: rising = 1, falling = 0 (IEEE 802.3 convention).
- Interval counter t:
  - Clears to 1 on the cycle an edge is counted as a mid-bit edge (TRACK) or on any edge (HUNT).
  - Otherwise increments, saturating at all-ones.
- Windows:
  - q = bit_cyc>>2
  - lo = bit_cyc-q
  - hi = bit_cyc+q
  - Windows are registered, so they follow a bit_cyc change one cycle later.
- HUNT:
  - On an edge with lo <= t <= hi (long run, so this is a mid-bit edge): go to TRACK, emit bit.
  - Any other edge: stay in HUNT, t restarts.
- TRACK:
  - Edge with t < q: glitch. Increment viol_cnt, go to HUNT.
  - Edge with q <= t < lo: cell-boundary edge. Ignore, t keeps counting.
  - Edge with lo <= t <= hi: mid-bit edge. Emit bit.
  - No edge and t > hi: timeout. Increment viol_cnt, go to HUNT.
  - Edge on the same cycle t reaches hi: the edge wins.
- Emit bit:
  - rx_bit = edge polarity.
  - rx_valid=1 for exactly one cycle.
  - rx_word <= {rx_word[SR_W-2:0], bit}.
- Latency: a sig_in transition sampled at clk edge k gives rx_valid high in cycle k+3.
- rx_clk:
  - Set to 1 on the rx_valid cycle.
  - Cleared when t reaches bit_cyc>>1.
  - Forced 0 whenever locked=0.
- locked = (state==TRACK), registered. Goes 0 on the cycle the decoder returns to HUNT.
- bit_cyc change while in TRACK: go to HUNT, no violation counted, rx_word retained.
- viol_cnt saturates at 255 and clears only on reset.
- Reset mid-bit: all state is discarded, and a new long run is required to relock.

Decomposition:
- Package manchester_rx_pkg:
  - state enum {HUNT, TRACK}
  - constant MIN_BIT_CYC = 8
  - constant VIOL_W = 8
- One sub-module, sig_sync_edge: 2-flop synchronizer plus edge register. Outputs level, edge, and rising.

Test Plan:
1. bit_cyc=20; send pattern 1,0,1,1,0,0 with a correct preamble edge → locked rises at the first long-run mid edge; rx_valid pulses every 20 cycles ±0; rx_word ends 0b..101100; viol_cnt=0.
2. All-ones stream, bit_cyc=20 (no long runs) → stays HUNT, locked=0, no rx_valid. Then insert a 0,1 transition → lock within 1 bit.
3. Locked at bit_cyc=20; hold sig_in static for 26 cycles → locked drops when t=26 (hi=25); viol_cnt=1; rx_clk=0.
4. Locked; inject a 3-cycle glitch (t<5) → viol_cnt+1, HUNT. Relock on the next long run; output bits after relock are correct.
5. Jitter: mid edges at t=15 and t=25 (bit_cyc=20) → both accepted. Edge at t=14 is treated as a boundary edge and ignored, then timeout.
6. Change bit_cyc 20→200 while locked → HUNT, no violation. Relock at the new rate; rx_clk high for 100 cycles per bit. Apply rst_n=0 mid-stream → all outputs 0 next cycle.
